// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use bubbles
//
// Accepts one decoded instruction per cycle from ID, resolves its operands
// (register file, MEM/WB forwarding, immediate, PC) and registers the ALU
// inputs plus EX-stage control. A load in EX whose destination is read by
// the instruction in ID causes one bubble; bubbles are counted (saturating).
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   id_valid / id_ready             ID handshake
//   id_rs1, id_rs2, id_rd           register indices
//   id_rs1_data, id_rs2_data        register file read data
//   id_imm, id_pc, id_alu_ctl       immediate, PC, ALU opcode
//   id_src_a_pc, id_src_b_imm       operand source selects
//   id_wb_en, id_is_load            writeback enable, load flag
//   mem_fwd_*, wb_fwd_*             forwarding sources (MEM wins over WB)
//   flush                           kill ID instruction and EX contents
//   ex_ready / ex_valid             EX downstream handshake
//   ALU_DA, ALU_DB, ALU_CTL         registered ALU inputs
//   ex_rd, ex_wb_en, ex_is_load     registered control
//   ex_store_data                   forwarded rs2 for stores
//   bubble_cnt                      saturating load-use bubble count
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [3:0]       id_alu_ctl,
  input  logic             id_src_a_pc,
  input  logic             id_src_b_imm,
  input  logic             id_wb_en,
  input  logic             id_is_load,
  input  logic             mem_fwd_en,
  input  logic [4:0]       mem_fwd_rd,
  input  logic [XLEN-1:0]  mem_fwd_data,
  input  logic             wb_fwd_en,
  input  logic [4:0]       wb_fwd_rd,
  input  logic [XLEN-1:0]  wb_fwd_data,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ALU_DA,
  output logic [XLEN-1:0]  ALU_DB,
  output logic [3:0]       ALU_CTL,
  output logic [4:0]       ex_rd,
  output logic             ex_wb_en,
  output logic             ex_is_load,
  output logic [XLEN-1:0]  ex_store_data,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_ex_valid;
  logic [XLEN-1:0]  r_alu_da;
  logic [XLEN-1:0]  r_alu_db;
  logic [3:0]       r_alu_ctl;
  logic [4:0]       r_ex_rd;
  logic             r_ex_wb_en;
  logic             r_ex_is_load;
  logic [XLEN-1:0]  r_store_data;
  logic [CNT_W-1:0] r_bubble_cnt;

  logic [XLEN-1:0]  w_fwd_rs1;
  logic [XLEN-1:0]  w_fwd_rs2;
  logic             w_hazard;
  logic             w_adv;

  // x0 always reads zero; the younger MEM result has priority over WB.
  always_comb begin
    w_fwd_rs1 = id_rs1_data;
    if (id_rs1 == 5'd0)
      w_fwd_rs1 = '0;
    else if (mem_fwd_en && (mem_fwd_rd == id_rs1))
      w_fwd_rs1 = mem_fwd_data;
    else if (wb_fwd_en && (wb_fwd_rd == id_rs1))
      w_fwd_rs1 = wb_fwd_data;
  end

  always_comb begin
    w_fwd_rs2 = id_rs2_data;
    if (id_rs2 == 5'd0)
      w_fwd_rs2 = '0;
    else if (mem_fwd_en && (mem_fwd_rd == id_rs2))
      w_fwd_rs2 = mem_fwd_data;
    else if (wb_fwd_en && (wb_fwd_rd == id_rs2))
      w_fwd_rs2 = wb_fwd_data;
  end

  // rs2 is checked even for immediate-form instructions: stores still read
  // rs2, and decoding which instructions really use it is not worth the cost.
  assign w_hazard = r_ex_valid && r_ex_is_load && (r_ex_rd != 5'd0) &&
                    ((r_ex_rd == id_rs1) || (r_ex_rd == id_rs2));
  assign w_adv    = !r_ex_valid || ex_ready;
  assign id_ready = flush || (w_adv && !w_hazard);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid   <= 1'b0;
      r_alu_da     <= '0;
      r_alu_db     <= '0;
      r_alu_ctl    <= '0;
      r_ex_rd      <= '0;
      r_ex_wb_en   <= 1'b0;
      r_ex_is_load <= 1'b0;
      r_store_data <= '0;
      r_bubble_cnt <= '0;
    end else if (flush) begin
      r_ex_valid   <= 1'b0;
      r_ex_wb_en   <= 1'b0;
      r_ex_is_load <= 1'b0;
    end else if (w_adv) begin
      if (id_valid && w_hazard) begin
        r_ex_valid   <= 1'b0;
        r_ex_wb_en   <= 1'b0;
        r_ex_is_load <= 1'b0;
        if (r_bubble_cnt != CNT_MAX)
          r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      end else if (id_valid) begin
        r_ex_valid   <= 1'b1;
        r_alu_da     <= id_src_a_pc  ? id_pc  : w_fwd_rs1;
        r_alu_db     <= id_src_b_imm ? id_imm : w_fwd_rs2;
        r_alu_ctl    <= id_alu_ctl;
        r_ex_rd      <= id_rd;
        r_ex_wb_en   <= id_wb_en;
        r_ex_is_load <= id_is_load;
        r_store_data <= w_fwd_rs2;
      end else begin
        r_ex_valid   <= 1'b0;
        r_ex_wb_en   <= 1'b0;
        r_ex_is_load <= 1'b0;
      end
    end
  end

  assign ex_valid      = r_ex_valid;
  assign ALU_DA        = r_alu_da;
  assign ALU_DB        = r_alu_db;
  assign ALU_CTL       = r_alu_ctl;
  assign ex_rd         = r_ex_rd;
  assign ex_wb_en      = r_ex_wb_en;
  assign ex_is_load    = r_ex_is_load;
  assign ex_store_data = r_store_data;
  assign bubble_cnt    = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid, id_ready;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic [3:0] id_alu_ctl;
  logic id_src_a_pc, id_src_b_imm, id_wb_en, id_is_load;
  logic mem_fwd_en, wb_fwd_en;
  logic [4:0] mem_fwd_rd, wb_fwd_rd;
  logic [XLEN-1:0] mem_fwd_data, wb_fwd_data;
  logic flush, ex_ready, ex_valid;
  logic [XLEN-1:0] ALU_DA, ALU_DB, ex_store_data;
  logic [3:0] ALU_CTL;
  logic [4:0] ex_rd;
  logic ex_wb_en, ex_is_load;
  logic [CNT_W-1:0] bubble_cnt;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_pc(id_pc), .id_alu_ctl(id_alu_ctl),
    .id_src_a_pc(id_src_a_pc), .id_src_b_imm(id_src_b_imm),
    .id_wb_en(id_wb_en), .id_is_load(id_is_load),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ALU_DA(ALU_DA), .ALU_DB(ALU_DB), .ALU_CTL(ALU_CTL),
    .ex_rd(ex_rd), .ex_wb_en(ex_wb_en), .ex_is_load(ex_is_load),
    .ex_store_data(ex_store_data), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v;
    logic [4:0] rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
    logic [3:0] ctl;
    logic apc, bimm, wb, ld;
    logic men; logic [4:0] mrd; logic [31:0] mdat;
    logic wen; logic [4:0] wrd; logic [31:0] wdat;
    logic fl, exr;
    logic e_rdy, e_val, chk_d;
    logic [31:0] e_da, e_db;
    logic [3:0] e_ctl;
    int e_cnt;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // reference state of the EX register
  logic m_valid, m_wb, m_ld;
  logic [31:0] m_da, m_db, m_st;
  logic [3:0] m_ctl;
  logic [4:0] m_rd;
  int m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t nop();
    vec_t v;
    v = '{default: '0};
    v.exr = 1'b1;
    v.e_rdy = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] fwd(input vec_t v, input logic [4:0] s, input logic [31:0] rf);
    if (s == 0) return 32'd0;
    if (v.men && v.mrd == s) return v.mdat;
    if (v.wen && v.wrd == s) return v.wdat;
    return rf;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_wb = 0; m_ld = 0; m_da = 0; m_db = 0; m_st = 0;
    m_ctl = 0; m_rd = 0; m_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, " ex_valid"}, ex_valid, m_valid);
    chk({tag, " ALU_DA"}, ALU_DA, m_da);
    chk({tag, " ALU_DB"}, ALU_DB, m_db);
    chk({tag, " ALU_CTL"}, ALU_CTL, m_ctl);
    chk({tag, " ex_rd"}, ex_rd, m_rd);
    chk({tag, " ex_wb_en"}, ex_wb_en, m_wb);
    chk({tag, " ex_is_load"}, ex_is_load, m_ld);
    chk({tag, " ex_store_data"}, ex_store_data, m_st);
    chk({tag, " bubble_cnt"}, bubble_cnt, m_cnt);
  endtask

  task automatic step(input vec_t v, input bit use_exp, input string tag);
    bit adv, haz, rdy;
    logic [31:0] f1, f2;
    id_valid = v.v; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
    id_rs1_data = v.d1; id_rs2_data = v.d2; id_imm = v.imm; id_pc = v.pc;
    id_alu_ctl = v.ctl; id_src_a_pc = v.apc; id_src_b_imm = v.bimm;
    id_wb_en = v.wb; id_is_load = v.ld;
    mem_fwd_en = v.men; mem_fwd_rd = v.mrd; mem_fwd_data = v.mdat;
    wb_fwd_en = v.wen; wb_fwd_rd = v.wrd; wb_fwd_data = v.wdat;
    flush = v.fl; ex_ready = v.exr;
    #1;
    adv = !m_valid || v.exr;
    haz = m_valid && m_ld && m_rd != 0 && (m_rd == v.rs1 || m_rd == v.rs2);
    rdy = v.fl || (adv && !haz);
    chk({tag, " id_ready"}, id_ready, rdy);
    if (use_exp) chk({tag, " exp id_ready"}, id_ready, v.e_rdy);
    f1 = fwd(v, v.rs1, v.d1);
    f2 = fwd(v, v.rs2, v.d2);
    @(posedge clk);
    #1;
    if (v.fl) begin
      m_valid = 0; m_wb = 0; m_ld = 0;
    end else if (adv) begin
      if (v.v && haz) begin
        m_valid = 0; m_wb = 0; m_ld = 0;
        if (m_cnt < CMAX) m_cnt++;
      end else if (v.v) begin
        m_valid = 1; m_wb = v.wb; m_ld = v.ld; m_rd = v.rd; m_ctl = v.ctl;
        m_da = v.apc ? v.pc : f1;
        m_db = v.bimm ? v.imm : f2;
        m_st = f2;
      end else begin
        m_valid = 0; m_wb = 0; m_ld = 0;
      end
    end
    check_outputs(tag);
    if (use_exp) begin
      chk({tag, " exp ex_valid"}, ex_valid, v.e_val);
      chk({tag, " exp bubble_cnt"}, bubble_cnt, v.e_cnt);
      if (v.chk_d) begin
        chk({tag, " exp ALU_DA"}, ALU_DA, v.e_da);
        chk({tag, " exp ALU_DB"}, ALU_DB, v.e_db);
        chk({tag, " exp ALU_CTL"}, ALU_CTL, v.e_ctl);
      end
    end
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    model_reset();
    v = nop();
    v.exr = 1'b0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rs1_data = 0; id_rs2_data = 0;
    id_imm = 0; id_pc = 0; id_alu_ctl = 0; id_src_a_pc = 0; id_src_b_imm = 0;
    id_wb_en = 0; id_is_load = 0; mem_fwd_en = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_fwd_en = 0; wb_fwd_rd = 0; wb_fwd_data = 0; flush = 0; ex_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    chk("reset id_ready", id_ready, 1'b1);
    rst_n = 1'b1;

    // T1 addu 5,7
    v = nop(); v.v = 1; v.rs1 = 1; v.rs2 = 2; v.rd = 5; v.d1 = 5; v.d2 = 7; v.wb = 1;
    v.e_val = 1; v.chk_d = 1; v.e_da = 5; v.e_db = 7; v.e_ctl = 4'b0000; tbl.push_back(v);
    // T2 xor x,0xFF
    v = nop(); v.v = 1; v.rs1 = 1; v.d1 = 32'hAA; v.imm = 32'hFF; v.bimm = 1; v.ctl = 4'b0110;
    v.e_val = 1; v.chk_d = 1; v.e_da = 32'hAA; v.e_db = 32'hFF; v.e_ctl = 4'b0110; tbl.push_back(v);
    // T3 MEM beats WB
    v = nop(); v.v = 1; v.rs1 = 3; v.d1 = 1; v.wen = 1; v.wrd = 3; v.wdat = 2;
    v.men = 1; v.mrd = 3; v.mdat = 9; v.e_val = 1; v.chk_d = 1; v.e_da = 9; tbl.push_back(v);
    // T4 WB only
    v.men = 0; v.e_da = 2; tbl.push_back(v);
    // T5 x0 ignores forwards
    v = nop(); v.v = 1; v.d1 = 32'h55; v.men = 1; v.mdat = 9; v.wen = 1; v.wdat = 2;
    v.e_val = 1; v.chk_d = 1; tbl.push_back(v);
    // T6 load rd=4
    v = nop(); v.v = 1; v.rd = 4; v.ld = 1; v.wb = 1; v.bimm = 1; v.imm = 32'h10;
    v.e_val = 1; v.chk_d = 1; v.e_db = 32'h10; tbl.push_back(v);
    // T7 dependent add -> bubble
    v = nop(); v.v = 1; v.rs1 = 4; v.ctl = 4'b0001; v.e_rdy = 0; v.e_cnt = 1; tbl.push_back(v);
    // T8 consumer accepted, load data from MEM
    v.men = 1; v.mrd = 4; v.mdat = 32'h1234; v.e_rdy = 1; v.e_val = 1; v.chk_d = 1;
    v.e_da = 32'h1234; v.e_ctl = 4'b0001; tbl.push_back(v);
    // T9 load rd=6
    v = nop(); v.v = 1; v.rd = 6; v.ld = 1; v.bimm = 1; v.imm = 32'h20; v.e_cnt = 1;
    v.e_val = 1; v.chk_d = 1; v.e_db = 32'h20; tbl.push_back(v);
    // T10-12 downstream stall holds EX
    v = nop(); v.v = 1; v.rs1 = 1; v.rs2 = 2; v.d1 = 32'h77; v.d2 = 3; v.ctl = 4'b0001;
    v.exr = 0; v.e_rdy = 0; v.e_val = 1; v.chk_d = 1; v.e_db = 32'h20; v.e_cnt = 1;
    repeat (3) tbl.push_back(v);
    // T13 stall released
    v.exr = 1; v.e_rdy = 1; v.e_da = 32'h77; v.e_db = 3; v.e_ctl = 4'b0001; tbl.push_back(v);
    // T14 load rd=7
    v = nop(); v.v = 1; v.rd = 7; v.ld = 1; v.bimm = 1; v.imm = 4; v.e_cnt = 1;
    v.e_val = 1; v.chk_d = 1; v.e_db = 4; tbl.push_back(v);
    // T15 hazard under stall: no bubble
    v = nop(); v.v = 1; v.rs2 = 7; v.bimm = 1; v.imm = 1; v.ctl = 4'b0011; v.exr = 0;
    v.e_rdy = 0; v.e_val = 1; v.e_cnt = 1; tbl.push_back(v);
    // T16 flush wins over hazard and stall
    v.fl = 1; v.e_rdy = 1; v.e_val = 0; tbl.push_back(v);
    // T17 re-presented after flush
    v.fl = 0; v.exr = 1; v.e_val = 1; v.chk_d = 1; v.e_db = 1; v.e_ctl = 4'b0011; tbl.push_back(v);
    // T18 load rd=9
    v = nop(); v.v = 1; v.rd = 9; v.ld = 1; v.e_val = 1; v.e_cnt = 1; tbl.push_back(v);
    // T19 rs2 hazard despite immediate operand
    v = nop(); v.v = 1; v.rs2 = 9; v.bimm = 1; v.imm = 5; v.e_rdy = 0; v.e_cnt = 2; tbl.push_back(v);
    // T20 accepted
    v.e_rdy = 1; v.e_val = 1; v.chk_d = 1; v.e_db = 5; tbl.push_back(v);
    // T21 idle drains EX
    v = nop(); v.e_cnt = 2; tbl.push_back(v);

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], 1'b1, $sformatf("tbl[%0d]", i));

    for (int i = 0; i < 3000; i++) begin
      v = nop();
      v.v = ($urandom_range(0, 9) < 8);
      v.rs1 = 5'($urandom_range(0, 3)); v.rs2 = 5'($urandom_range(0, 3));
      v.rd = 5'($urandom_range(0, 3));
      v.d1 = $urandom; v.d2 = $urandom; v.imm = $urandom; v.pc = $urandom;
      v.ctl = 4'($urandom); v.apc = 1'($urandom); v.bimm = 1'($urandom);
      v.wb = 1'($urandom); v.ld = 1'($urandom);
      v.men = 1'($urandom); v.mrd = 5'($urandom_range(0, 3)); v.mdat = $urandom;
      v.wen = 1'($urandom); v.wrd = 5'($urandom_range(0, 3)); v.wdat = $urandom;
      v.fl = ($urandom_range(0, 9) == 0);
      v.exr = ($urandom_range(0, 3) != 0);
      step(v, 1'b0, $sformatf("rnd[%0d]", i));
    end

    // saturation: a self-dependent load bubbles every other cycle
    v = nop(); v.v = 1; v.rs1 = 8; v.rd = 8; v.ld = 1; v.wb = 1;
    for (int i = 0; i < 2 * (CMAX + 20); i++)
      step(v, 1'b0, "sat");
    chk("sat bubble_cnt", bubble_cnt, CMAX);

    // asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    #3;
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
